// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_pkg;

    localparam int unsigned CMD_RD_BIT = 7;
    localparam int unsigned SPI_ADDR_W = 7;
    localparam int unsigned SPI_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_REQ,
        RD_CAP,
        READ
    } spi_bridge_state_t;

    // Address step after a data byte; 7-bit arithmetic wraps 7'h7F to 7'h00.
    function automatic logic [SPI_ADDR_W-1:0] next_addr(input logic [SPI_ADDR_W-1:0] addr,
                                                        input bit                    inc);
        return inc ? addr + 7'd1 : addr;
    endfunction

endpackage

// File: rtl/spi_reg_bridge.sv
// Frames each ss-low SPI transaction into a command byte followed by auto-incrementing
// register writes, or prefetched register reads fed back as the next transmit byte.
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter logic [SPI_DATA_W-1:0] STATUS_BYTE = 8'hA5,
    parameter bit                    AUTO_INC    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic [SPI_DATA_W-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [SPI_DATA_W-1:0] tx_data,
    output logic                  tx_valid,
    output logic [SPI_ADDR_W-1:0] reg_addr,
    output logic [SPI_DATA_W-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [SPI_DATA_W-1:0] reg_rdata,
    output logic                  busy
);

    spi_bridge_state_t     state_q;
    logic                  rx_valid_q;
    logic [SPI_DATA_W-1:0] tx_data_q;
    logic                  tx_valid_q;
    logic [SPI_ADDR_W-1:0] reg_addr_q;
    logic [SPI_DATA_W-1:0] reg_wdata_q;
    logic                  reg_we_q;
    logic                  reg_re_q;
    logic                  rx_evt;

    // rx_valid is a level that can stay high across many cycles; only its rise is a byte.
    assign rx_evt = rx_valid & ~rx_valid_q & ~ss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            if (ss) begin
                // Deselect wins over everything, including a byte arriving this cycle.
                state_q    <= IDLE;
                tx_data_q  <= '0;
                tx_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q    <= CMD;
                        tx_data_q  <= STATUS_BYTE;
                        tx_valid_q <= 1'b1;
                    end
                    CMD: begin
                        if (rx_evt) begin
                            reg_addr_q <= rx_data[SPI_ADDR_W-1:0];
                            if (rx_data[CMD_RD_BIT]) begin
                                state_q  <= RD_REQ;
                                reg_re_q <= 1'b1;
                            end else begin
                                state_q   <= WRITE;
                                tx_data_q <= '0;
                            end
                        end
                    end
                    WRITE: begin
                        if (reg_we_q) begin
                            reg_addr_q <= next_addr(reg_addr_q, AUTO_INC);
                        end
                        if (rx_evt) begin
                            reg_we_q    <= 1'b1;
                            reg_wdata_q <= rx_data;
                        end
                    end
                    RD_REQ: begin
                        state_q <= RD_CAP;
                    end
                    RD_CAP: begin
                        tx_data_q  <= reg_rdata;
                        reg_addr_q <= next_addr(reg_addr_q, AUTO_INC);
                        state_q    <= READ;
                    end
                    READ: begin
                        if (rx_evt) begin
                            state_q  <= RD_REQ;
                            reg_re_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Randomized bench for spi_reg_bridge: two instances (auto-increment on and off) share
// stimulus and are checked against a transaction-level model of register traffic.
module tb_spi_reg_bridge;

    localparam logic [7:0] Status = 8'hA5;
    localparam int KCmd = 0;
    localparam int KWr  = 1;
    localparam int KRd  = 2;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       ss       = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;

    logic [7:0] tx_data_a, tx_data_b, wdata_a, wdata_b, rdata_a, rdata_b;
    logic [6:0] addr_a, addr_b;
    logic       tx_valid_a, tx_valid_b, we_a, we_b, re_a, re_b, busy_a, busy_b;

    always #5 clk = ~clk;

    spi_reg_bridge #(.STATUS_BYTE(Status), .AUTO_INC(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .ss(ss), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .reg_addr(addr_a), .reg_wdata(wdata_a),
        .reg_we(we_a), .reg_re(re_a), .reg_rdata(rdata_a), .busy(busy_a)
    );

    spi_reg_bridge #(.STATUS_BYTE(Status), .AUTO_INC(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .ss(ss), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .reg_addr(addr_b), .reg_wdata(wdata_b),
        .reg_we(we_b), .reg_re(re_b), .reg_rdata(rdata_b), .busy(busy_b)
    );

    // Register-bus slaves: read data valid one clock after reg_re.
    logic [7:0] init_tbl [128];
    logic [7:0] mem_a [128];
    logic [7:0] mem_b [128];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) begin
                mem_a[i] <= init_tbl[i];
                mem_b[i] <= init_tbl[i];
            end
            rdata_a <= 8'h00;
            rdata_b <= 8'h00;
        end else begin
            if (re_a) rdata_a <= mem_a[addr_a];
            if (we_a) mem_a[addr_a] <= wdata_a;
            if (re_b) rdata_b <= mem_b[addr_b];
            if (we_b) mem_b[addr_b] <= wdata_b;
        end
    end

    // Bus monitor: every strobe cycle is logged; a 2-cycle pulse shows up as two entries.
    logic [14:0] obs_we_a[$], obs_we_b[$];
    logic [6:0]  obs_re_a[$], obs_re_b[$];
    int          overlap = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (we_a) obs_we_a.push_back({addr_a, wdata_a});
            if (we_b) obs_we_b.push_back({addr_b, wdata_b});
            if (re_a) obs_re_a.push_back(addr_a);
            if (re_b) obs_re_b.push_back(addr_b);
            if ((we_a && re_a) || (we_b && re_b)) overlap++;
        end
    end

    // Reference model state
    logic [7:0]  ref_a [128];
    logic [7:0]  ref_b [128];
    logic [14:0] exp_we_a[$], exp_we_b[$];
    logic [6:0]  exp_re_a[$], exp_re_b[$];
    logic [6:0]  m_addr_a, m_addr_b;
    logic [7:0]  m_tx_a, m_tx_b;
    logic [7:0]  payload[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic sync_ref();
        for (int i = 0; i < 128; i++) begin
            ref_a[i] = init_tbl[i];
            ref_b[i] = init_tbl[i];
        end
    endtask

    // Each read-path byte fetches the register at the running address and moves on.
    task automatic model_prefetch();
        exp_re_a.push_back(m_addr_a);
        exp_re_b.push_back(m_addr_b);
        m_tx_a   = ref_a[m_addr_a];
        m_tx_b   = ref_b[m_addr_b];
        m_addr_a = 7'((int'(m_addr_a) + 1) % 128);
    endtask

    task automatic model_write(input logic [7:0] d);
        exp_we_a.push_back({m_addr_a, d});
        exp_we_b.push_back({m_addr_b, d});
        ref_a[m_addr_a] = d;
        ref_b[m_addr_b] = d;
        m_addr_a = 7'((int'(m_addr_a) + 1) % 128);
    endtask

    function automatic int pick_hold();
        return ($urandom_range(0, 9) == 0) ? 50 : int'($urandom_range(0, 3));
    endfunction

    // Called at a negedge; ovr injects a second rx_valid rise while the prefetch is in flight.
    task automatic send_byte(input logic [7:0] b, input int kind, input int hold, input bit ovr);
        logic [7:0] old_a, old_b;
        bit         rd;
        old_a = m_tx_a;
        old_b = m_tx_b;
        rd    = (kind == KRd) || (kind == KCmd && b[7]);
        if (kind == KCmd) begin
            m_addr_a = b[6:0];
            m_addr_b = b[6:0];
            if (b[7]) begin
                model_prefetch();
            end else begin
                m_tx_a = 8'h00;
                m_tx_b = 8'h00;
            end
        end else if (kind == KWr) begin
            model_write(b);
        end else begin
            model_prefetch();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        if (kind == KWr) begin
            check_eq("we_latency_a", we_a, 1);
            check_eq("we_latency_b", we_b, 1);
        end
        if (rd && ovr) rx_valid = 1'b0;
        step();
        if (rd) begin
            check_eq("tx_hold_a", tx_data_a, old_a);
            check_eq("tx_hold_b", tx_data_b, old_b);
        end
        if (rd && ovr) rx_valid = 1'b1;
        step();
        check_eq("tx_data_a", tx_data_a, m_tx_a);
        check_eq("tx_data_b", tx_data_b, m_tx_b);
        check_eq("tx_valid_a", tx_valid_a, 1);
        repeat (hold) step();
        rx_valid = 1'b0;
        repeat ($urandom_range(4, 8)) step();
    endtask

    // One ss-low transaction using payload as data/dummy bytes.
    task automatic xfer(input bit rd, input logic [6:0] a, input bit sim_end);
        int bwa, bwb, bra, brb, n;
        bwa = obs_we_a.size();
        bwb = obs_we_b.size();
        bra = obs_re_a.size();
        brb = obs_re_b.size();
        exp_we_a.delete();
        exp_we_b.delete();
        exp_re_a.delete();
        exp_re_b.delete();
        ss = 1'b0;
        step();
        check_eq("start_tx_valid", {tx_valid_a, tx_valid_b}, 2'b11);
        check_eq("start_status_a", tx_data_a, Status);
        check_eq("start_status_b", tx_data_b, Status);
        check_eq("start_busy", {busy_a, busy_b}, 2'b11);
        m_tx_a = Status;
        m_tx_b = Status;
        repeat ($urandom_range(1, 4)) step();
        send_byte({rd, a}, KCmd, pick_hold(), 1'b0);
        foreach (payload[i]) begin
            send_byte(payload[i], rd ? KRd : KWr, pick_hold(),
                      rd && ($urandom_range(0, 3) == 0));
        end
        if (sim_end) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
        end
        ss = 1'b1;
        step();
        check_eq("end_busy", {busy_a, busy_b}, 2'b00);
        check_eq("end_tx_valid", {tx_valid_a, tx_valid_b}, 2'b00);
        check_eq("end_tx_data", {tx_data_a, tx_data_b}, 16'h0000);
        repeat (3) step();
        rx_valid = 1'b0;
        repeat (3) step();
        n = obs_we_a.size() - bwa;
        check_eq("we_count_a", n, exp_we_a.size());
        for (int i = 0; i < n && i < exp_we_a.size(); i++)
            check_eq("we_a", obs_we_a[bwa+i], exp_we_a[i]);
        n = obs_we_b.size() - bwb;
        check_eq("we_count_b", n, exp_we_b.size());
        for (int i = 0; i < n && i < exp_we_b.size(); i++)
            check_eq("we_b", obs_we_b[bwb+i], exp_we_b[i]);
        n = obs_re_a.size() - bra;
        check_eq("re_count_a", n, exp_re_a.size());
        for (int i = 0; i < n && i < exp_re_a.size(); i++)
            check_eq("re_a", obs_re_a[bra+i], exp_re_a[i]);
        n = obs_re_b.size() - brb;
        check_eq("re_count_b", n, exp_re_b.size());
        for (int i = 0; i < n && i < exp_re_b.size(); i++)
            check_eq("re_b", obs_re_b[brb+i], exp_re_b[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_data"}, {tx_data_a, tx_data_b}, 16'h0000);
        check_eq({tag, "_tx_valid"}, {tx_valid_a, tx_valid_b}, 2'b00);
        check_eq({tag, "_addr"}, {addr_a, addr_b}, 14'h0000);
        check_eq({tag, "_wdata"}, {wdata_a, wdata_b}, 16'h0000);
        check_eq({tag, "_strobes"}, {we_a, re_a, we_b, re_b}, 4'b0000);
        check_eq({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
    endtask

    initial begin
        int bra, brb, bwa, bwb;
        for (int i = 0; i < 128; i++) init_tbl[i] = 8'($urandom);
        sync_ref();
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // Directed: basic write, readback, address wrap
        payload = '{8'h3C, 8'hC3};
        xfer(1'b0, 7'h05, 1'b0);
        payload = '{8'h11, 8'h22};
        xfer(1'b0, 7'h10, 1'b0);
        payload = '{8'h00, 8'h00};
        xfer(1'b1, 7'h10, 1'b0);
        payload = '{8'hAA, 8'hBB};
        xfer(1'b0, 7'h7F, 1'b0);
        payload = '{8'h5A};
        xfer(1'b0, 7'h20, 1'b1);

        for (int t = 0; t < 40; t++) begin
            payload.delete();
            repeat ($urandom_range(0, 4)) payload.push_back(8'($urandom));
            xfer(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 7'($urandom_range(124, 127)) : 7'($urandom),
                 $urandom_range(0, 3) == 0);
        end

        // Asynchronous reset in the middle of a read transaction
        ss = 1'b0;
        step();
        rx_data  = 8'h85;
        rx_valid = 1'b1;
        repeat (5) step();
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        ss       = 1'b1;
        rx_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        sync_ref();
        bwa = obs_we_a.size();
        bwb = obs_we_b.size();
        bra = obs_re_a.size();
        brb = obs_re_b.size();
        repeat (5) step();
        check_eq("post_rst_tx_valid", {tx_valid_a, tx_valid_b}, 2'b00);
        check_eq("post_rst_busy", {busy_a, busy_b}, 2'b00);
        check_eq("post_rst_strobes", (obs_we_a.size() - bwa) + (obs_we_b.size() - bwb) +
                 (obs_re_a.size() - bra) + (obs_re_b.size() - brb), 0);

        payload = '{8'h00};
        xfer(1'b1, 7'h05, 1'b0);

        check_eq("we_re_exclusive", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
